// File: rtl/tbus_reader.sv
// tbus_reader: read sequencer for a shared tri-state bus.
// Enables one source at a time, captures after a settle delay, then
// holds every enable off for a turnaround gap before the next read.
module tbus_reader #(
    parameter int DW     = 8,
    parameter int SEL_W  = 2,
    parameter int SETTLE = 2,
    parameter int TURN   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic [SEL_W-1:0]      src_sel,
    input  logic [DW-1:0]         bus_in,
    output logic [2**SEL_W-1:0]   oe_n,
    output logic [DW-1:0]         rd_data,
    output logic                  rd_valid,
    output logic                  busy
);
    localparam int N_SRC = 2**SEL_W;
    // The counter is shared by the settle and turnaround phases.
    localparam int CMAX  = (SETTLE > TURN) ? SETTLE : TURN;
    localparam int CW    = $clog2(CMAX + 1);
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE - 1);
    // Guarded so TURN = 0 never produces a negative load value.
    localparam logic [CW-1:0] TURN_LD   = (TURN > 0) ? CW'(TURN - 1) : '0;

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_TURN} state_t;

    state_t             r_state, w_state_nxt;
    logic [CW-1:0]      r_cnt, w_cnt_nxt;
    logic [SEL_W-1:0]   r_sel, w_sel_nxt;
    logic [N_SRC-1:0]   r_oe_n, w_oe_nxt;
    logic [DW-1:0]      r_data, w_data_nxt;
    logic               r_valid, w_valid_nxt;
    logic [N_SRC-1:0]   w_dec_req;
    logic [N_SRC-1:0]   w_dec_held;

    // One-hot-low enable patterns for the incoming and the latched source.
    assign w_dec_req  = ~(N_SRC'(1) << src_sel);
    assign w_dec_held = ~(N_SRC'(1) << r_sel);

    // State and datapath registers; reset overrides any pending request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_sel   <= '0;
            r_oe_n  <= '1;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sel   <= w_sel_nxt;
            r_oe_n  <= w_oe_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    // Next-state and next-output logic; bus_in is only looked at on the capture edge.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = r_sel;
        w_oe_nxt    = r_oe_n;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_oe_nxt = '1;
                if (req) begin
                    w_sel_nxt   = src_sel;
                    w_oe_nxt    = w_dec_req;
                    w_cnt_nxt   = SETTLE_LD;
                    w_state_nxt = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                    w_oe_nxt  = w_dec_held;
                end else begin
                    w_data_nxt  = bus_in;
                    w_valid_nxt = 1'b1;
                    w_oe_nxt    = '1;
                    if (TURN > 0) begin
                        w_state_nxt = S_TURN;
                        w_cnt_nxt   = TURN_LD;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_TURN: begin
                w_oe_nxt = '1;
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_oe_nxt    = '1;
            end
        endcase
    end

    assign oe_n     = r_oe_n;
    assign rd_data  = r_data;
    assign rd_valid = r_valid;
    assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_tbus_reader.sv
// Directed bench for tbus_reader: default build (SETTLE=2, TURN=1) plus
// a SETTLE=1, TURN=0 corner build sharing the clock and reset.
module tb_tbus_reader;
    logic       clk = 1'b0;
    logic       rst;
    logic       req, req1;
    logic [1:0] src_sel, sel1;
    logic [7:0] bus_in, bus1;
    logic [3:0] oe_n, oe_n1;
    logic [7:0] rd_data, rd_data1;
    logic       rd_valid, rd_valid1, busy, busy1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tbus_reader #(.DW(8), .SEL_W(2), .SETTLE(2), .TURN(1)) dut (
        .clk(clk), .rst(rst), .req(req), .src_sel(src_sel), .bus_in(bus_in),
        .oe_n(oe_n), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy));

    tbus_reader #(.DW(8), .SEL_W(2), .SETTLE(1), .TURN(0)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .src_sel(sel1), .bus_in(bus1),
        .oe_n(oe_n1), .rd_data(rd_data1), .rd_valid(rd_valid1), .busy(busy1));

    function automatic logic [7:0] src_val(input int i);
        case (i)
            0:       return 8'h3C;
            1:       return 8'h5A;
            2:       return 8'hA5;
            default: return 8'hC3;
        endcase
    endfunction

    // Tri-state bus model: enabled source drives, otherwise undriven.
    always_comb begin
        bus_in = 'x;
        for (int i = 0; i < 4; i++) if (!oe_n[i]) bus_in = src_val(i);
    end
    always_comb begin
        bus1 = 'x;
        for (int i = 0; i < 4; i++) if (!oe_n1[i]) bus1 = src_val(i);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge (start of next cycle).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int lows(input logic [3:0] v);
        int c = 0;
        for (int i = 0; i < 4; i++) if (!v[i]) c++;
        return c;
    endfunction

    logic [3:0] exp_oe [0:5];

    initial begin
        rst = 1'b1; req = 1'b1; src_sel = 2'd2; req1 = 1'b0; sel1 = 2'd0;

        // 1. reset held two cycles with req high
        for (int c = 0; c < 2; c++) begin
            tick();
            check("rst_oe",    32'(oe_n),     32'hF);
            check("rst_data",  32'(rd_data),  32'h00);
            check("rst_valid", 32'(rd_valid), 32'h0);
            check("rst_busy",  32'(busy),     32'h0);
        end
        rst = 1'b0; req = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 32'h0);

        // 2. single read of source 2
        req = 1'b1; src_sel = 2'd2;
        tick();                             // cycle 0
        req = 1'b0;
        check("s2_c0_oe",   32'(oe_n),     32'hB);
        check("s2_c0_busy", 32'(busy),     32'h1);
        check("s2_c0_vld",  32'(rd_valid), 32'h0);
        tick();                             // cycle 1
        check("s2_c1_oe",   32'(oe_n),     32'hB);
        check("s2_c1_vld",  32'(rd_valid), 32'h0);
        tick();                             // cycle 2
        check("s2_c2_vld",  32'(rd_valid), 32'h1);
        check("s2_c2_data", 32'(rd_data),  32'hA5);
        check("s2_c2_oe",   32'(oe_n),     32'hF);
        check("s2_c2_busy", 32'(busy),     32'h1);
        tick();                             // cycle 3
        check("s2_c3_busy", 32'(busy),     32'h0);
        check("s2_c3_vld",  32'(rd_valid), 32'h0);
        check("s2_c3_hold", 32'(rd_data),  32'hA5);

        // 3. back-to-back with req held, source 1 then 3
        exp_oe[0] = 4'hD; exp_oe[1] = 4'hD; exp_oe[2] = 4'hF;
        exp_oe[3] = 4'hF; exp_oe[4] = 4'h7; exp_oe[5] = 4'h7;
        req = 1'b1; src_sel = 2'd1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (c == 0) src_sel = 2'd3;
            if (c == 4) req = 1'b0;
            check($sformatf("b2b_c%0d_oe", c), 32'(oe_n), 32'(exp_oe[c]));
            check($sformatf("b2b_c%0d_one", c), 32'(lows(oe_n) <= 1), 32'h1);
            if (c == 2) check("b2b_c2_data", 32'(rd_data), 32'h5A);
        end
        tick();                             // cycle 6
        check("b2b_c6_vld",  32'(rd_valid), 32'h1);
        check("b2b_c6_data", 32'(rd_data),  32'hC3);
        tick();
        tick();                             // cycle 8
        check("b2b_c8_busy", 32'(busy), 32'h0);

        // 4. request during a read is ignored
        req = 1'b1; src_sel = 2'd2;
        tick();                             // cycle 0
        req = 1'b0;
        tick();                             // cycle 1
        req = 1'b1; src_sel = 2'd0;
        check("ign_c1_oe", 32'(oe_n), 32'hB);
        tick();                             // cycle 2
        req = 1'b0;
        check("ign_c2_data", 32'(rd_data),  32'hA5);
        check("ign_c2_vld",  32'(rd_valid), 32'h1);
        check("ign_c2_oe",   32'(oe_n),     32'hF);
        tick();                             // cycle 3
        check("ign_c3_oe",   32'(oe_n), 32'hF);
        check("ign_c3_busy", 32'(busy), 32'h0);

        // 5. reset at edge 1 of a read
        req = 1'b1; src_sel = 2'd2;
        tick();                             // cycle 0
        req = 1'b0; rst = 1'b1;
        check("mr_c0_oe", 32'(oe_n), 32'hB);
        tick();                             // cycle 1
        rst = 1'b0;
        check("mr_c1_oe",   32'(oe_n),     32'hF);
        check("mr_c1_vld",  32'(rd_valid), 32'h0);
        check("mr_c1_data", 32'(rd_data),  32'h00);
        check("mr_c1_busy", 32'(busy),     32'h0);
        tick();                             // cycle 2
        check("mr_c2_vld",  32'(rd_valid), 32'h0);
        check("mr_c2_data", 32'(rd_data),  32'h00);

        // 6. SETTLE=1, TURN=0 with req held on source 1
        req1 = 1'b1; sel1 = 2'd1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (c % 2 == 0) begin
                check($sformatf("p6_c%0d_oe", c),  32'(oe_n1),     32'hD);
                check($sformatf("p6_c%0d_vld", c), 32'(rd_valid1), 32'h0);
                check($sformatf("p6_c%0d_bsy", c), 32'(busy1),     32'h1);
            end else begin
                check($sformatf("p6_c%0d_oe", c),  32'(oe_n1),     32'hF);
                check($sformatf("p6_c%0d_vld", c), 32'(rd_valid1), 32'h1);
                check($sformatf("p6_c%0d_dat", c), 32'(rd_data1),  32'h5A);
                check($sformatf("p6_c%0d_bsy", c), 32'(busy1),     32'h0);
            end
        end
        req1 = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
